// File: rtl/key_pulse_conditioner.sv
// Debounced one-shot conditioner for the two active-low player buttons (L, R).
// Optional build macro KEY_TIE_CANCEL_EN suppresses both pulses when L and R accept on the same cycle.
module key_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  // state     | meaning
  // IDLE      | key released, waiting for a synced press
  // PRESS_CHK | press seen, counting stable pressed samples
  // DOWN      | press accepted (pulse issued), key held
  // REL_CHK   | release seen, counting stable released samples
  typedef enum logic [1:0] {IDLE, PRESS_CHK, DOWN, REL_CHK} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0] key_n;
  logic [1:0] accept;
  logic [1:0] pulse;
  logic [1:0] held;
  logic       tie;

  assign key_n = {key_r_n, key_l_n};

`ifdef KEY_TIE_CANCEL_EN
  assign tie = accept[0] & accept[1];
`else
  assign tie = 1'b0;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   p;
    logic                   pulse_q;
    logic                   held_q;

    assign p         = ~sync_q[SYNC_STAGES-1];
    // Acceptance is the PRESS_CHK -> DOWN transition; a cancelled tie still moves to DOWN.
    assign accept[i] = (state == PRESS_CHK) && p && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q  <= '1;
        state   <= IDLE;
        cnt     <= '0;
        pulse_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n[i]};
        pulse_q <= accept[i] & ~tie;
        case (state)
          IDLE: begin
            if (p) begin
              state <= PRESS_CHK;
              cnt   <= CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!p) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state  <= DOWN;
              cnt    <= '0;
              held_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DOWN: begin
            if (!p) begin
              state <= REL_CHK;
              cnt   <= CNT_ONE;
            end
          end
          REL_CHK: begin
            if (p) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state  <= IDLE;
              cnt    <= '0;
              held_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
          end
        endcase
      end
    end

    assign pulse[i] = pulse_q;
    assign held[i]  = held_q;
  end

  assign L      = pulse[0];
  assign R      = pulse[1];
  assign held_l = held[0];
  assign held_r = held[1];

endmodule

// File: doc/key_pulse_conditioner.md
Name: key_pulse_conditioner

Overview:
- Conditions the two raw, active-low, bouncy player push-buttons for the tug-of-war playfield.
- Produces one clean, single-cycle, active-high press pulse per physical press on L and R. These outputs feed the L/R inputs of every playfield light cell.
- Each channel has three stages: a synchronizer, a debounce counter FSM and a one-shot. Holding a key never yields more than one pulse.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer chain (legal range 2 or more).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (legal range 1 or more; use 4 in simulation, about 500000 on the board).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- key_l_n  input  1  raw left button, 0 = pressed, asynchronous to clk.
- key_r_n  input  1  raw right button, 0 = pressed, asynchronous to clk.
- L  output  1  registered one-cycle pulse, left press accepted.
- R  output  1  registered one-cycle pulse, right press accepted.
- held_l  output  1  registered level, left key debounced-down.
- held_r  output  1  registered level, right key debounced-down.

Behaviour:
- Reset (reset = 0, asynchronous assert, synchronous-to-clk deassert handled externally):
  - All synchronizer flops load 1 (released).
  - Both FSMs go to IDLE and both counters go to 0.
  - L, R, held_l and held_r are all 0.
- Synchronizer: SYNC_STAGES flops per key. The FSM sees p = ~sync_out (1 = pressed).
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- Per-channel FSM states:
  - IDLE: if p = 1, go to PRESS_CHK with cnt = 1.
  - PRESS_CHK:
    - If p = 0, go to IDLE with cnt = 0.
    - Else if cnt == DEBOUNCE_CYCLES, go to DOWN and assert the pulse.
    - Else cnt++.
  - DOWN: if p = 0, go to REL_CHK with cnt = 1.
  - REL_CHK:
    - If p = 1, go to DOWN with cnt = 0 and no new pulse.
    - Else if cnt == DEBOUNCE_CYCLES, go to IDLE.
    - Else cnt++.
- Pulse timing:
  - The pulse is registered and is high for exactly the one cycle following the transition into DOWN.
  - Latency: let t0 be the first edge sampling the raw key as 0, with the key held. L is high in the cycle after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES. That is edge t0+6 at the defaults.
  - DEBOUNCE_CYCLES = 1 accepts any press seen for 2 consecutive synced samples.
- Held outputs: held_x = 1 in DOWN and REL_CHK, registered in the same way as the pulse.
- Boundary conditions:
  - Glitch shorter than the window: no pulse, FSM returns to IDLE.
  - Release bounce while DOWN: no second pulse.
  - Sustained hold: exactly one pulse, with held_x = 1 for the whole hold.
- Channels are fully independent. Simultaneous L and R pulses in the same cycle are legal and both are emitted; see the optional feature.
- Reset mid-press: all state clears and any outputs drop immediately. If the key is still down after reset deasserts, it is treated as a new press: full latency, then one pulse.

Optional Feature:
- Macro: KEY_TIE_CANCEL_EN.
- Defined: if both channels would pulse in the same cycle, L and R are both forced to 0 for that cycle (tie cancelled). held_l and held_r are unaffected, and neither FSM re-pulses later for that press.
- Undefined: both pulses are output unchanged, and downstream cells interpret L&R as no move.

Test Plan:
- Reset, then key_l_n=0 held 20 cycles (defaults) -> L=1 exactly in the cycle after edge t0+6, L=0 otherwise; held_l rises with L and stays 1; R=0 throughout.
- key_r_n=0 for 3 cycles, then 1 -> R never asserts, held_r stays 0, FSM back in IDLE (next clean press still gives full latency).
- Accepted left press, then key_l_n toggles 1,0,1,0 with 1-cycle periods, then held 0 -> no second L pulse, held_l remains 1; release held 10 cycles -> held_l falls after release debounce.
- Both keys go low on the same edge and are held -> with macro undefined, L=R=1 in the same single cycle; with KEY_TIE_CANCEL_EN, L=R=0 always while held_l=held_r=1.
- key_l_n low; assert reset=0 (asynchronously, between edges) in the cycle L is high -> L and held_l drop to 0 immediately; deassert with key still low -> exactly one L pulse SYNC_STAGES+DEBOUNCE_CYCLES edges later.
- DEBOUNCE_CYCLES=1, press held 2 cycles -> exactly one L pulse at latency SYNC_STAGES+1; press held 1 cycle -> none.
